// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the counter and the registered decoder.
// Functions work at N_MAX width; callers zero-extend their N-bit operands and truncate the result.
package gray_pkg;

  localparam int N_MAX = 32;

  function automatic logic [N_MAX-1:0] bin2gray(input logic [N_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero upper bits stay zero through the prefix chain, so a narrower operand decodes correctly.
  function automatic logic [N_MAX-1:0] gray2bin(input logic [N_MAX-1:0] g);
    logic [N_MAX-1:0] b;
    b[N_MAX-1] = g[N_MAX-1];
    for (int i = N_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_reg.sv
// Registered Gray-to-binary decoder with a matching valid flop.
// Also instantiated standalone on the far-domain side of an async FIFO.
module gray2bin_reg
  import gray_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] gray_in,
  input  logic         gray_in_vld,
  output logic [N-1:0] dec_bin,
  output logic         dec_vld
);

  logic [N-1:0] dec_bin_d, dec_bin_q;
  logic         dec_vld_d, dec_vld_q;

  // Decode runs every cycle; downstream qualifies with dec_vld.
  always_comb begin
    dec_bin_d = N'(gray2bin(N_MAX'(gray_in)));
    dec_vld_d = gray_in_vld;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_bin_q <= '0;
      dec_vld_q <= 1'b0;
    end else begin
      dec_bin_q <= dec_bin_d;
      dec_vld_q <= dec_vld_d;
    end
  end

  assign dec_bin = dec_bin_q;
  assign dec_vld = dec_vld_q;

endmodule

// File: rtl/gray_counter_nbits.sv
// N-bit up/down counter with loadable value, registered binary and Gray views, and wrap pulse.
// Carries an independent registered Gray decoder for pointers arriving from another domain.
module gray_counter_nbits
  import gray_pkg::*;
#(
  parameter int           N       = 8,
  parameter logic [N-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         up_dn,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] bin_out,
  output logic [N-1:0] gray_out,
  output logic         wrap,
  input  logic [N-1:0] gray_in,
  input  logic         gray_in_vld,
  output logic [N-1:0] dec_bin,
  output logic         dec_vld
);

  logic [N-1:0] bin_d, bin_q;
  logic [N-1:0] gray_d, gray_q;
  logic         wrap_d, wrap_q;

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_val;
    end else if (en) begin
      if (up_dn) begin
        bin_d  = bin_q + N'(1);
        wrap_d = &bin_q;
      end else begin
        bin_d  = bin_q - N'(1);
        wrap_d = ~|bin_q;
      end
    end
    // Gray is registered from the next binary value so the output never glitches across CDC.
    gray_d = N'(bin2gray(N_MAX'(bin_d)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= RST_VAL;
      gray_q <= RST_VAL ^ (RST_VAL >> 1);
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign wrap     = wrap_q;

  gray2bin_reg #(
    .N(N)
  ) u_dec (
    .clk        (clk),
    .rst_n      (rst_n),
    .gray_in    (gray_in),
    .gray_in_vld(gray_in_vld),
    .dec_bin    (dec_bin),
    .dec_vld    (dec_vld)
  );

endmodule

// File: tb/tb_gray_counter_nbits.sv
// Bench for gray_counter_nbits at N=4/RST_VAL=0 and N=8/RST_VAL=FE, driven in lockstep.
module tb_gray_counter_nbits;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, up_dn, load, gvld;
  logic [3:0] lv4, gin4, bin4, gray4, dec4;
  logic [7:0] lv8, gin8, bin8, gray8, dec8;
  logic       wrap4, dvld4, wrap8, dvld8;

  int checks = 0;
  int errors = 0;

  int   m4, m8, md4, md8;
  logic mw4, mw8, mdv;

  gray_counter_nbits #(.N(4), .RST_VAL(4'h0)) u4 (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_val(lv4),
    .bin_out(bin4), .gray_out(gray4), .wrap(wrap4),
    .gray_in(gin4), .gray_in_vld(gvld), .dec_bin(dec4), .dec_vld(dvld4)
  );

  gray_counter_nbits #(.N(8), .RST_VAL(8'hFE)) u8 (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_val(lv8),
    .bin_out(bin8), .gray_out(gray8), .wrap(wrap8),
    .gray_in(gin8), .gray_in_vld(gvld), .dec_bin(dec8), .dec_vld(dvld8)
  );

  typedef struct {
    logic       load;
    logic       en;
    logic       up_dn;
    logic [3:0] load_val;
    logic [3:0] exp_bin;
    logic [3:0] exp_gray;
    logic       exp_wrap;
  } vec_t;

  vec_t tbl[16];

  function automatic int gray_of(int b);
    return b ^ (b >> 1);
  endfunction

  // Inverse found by search over the code space rather than by an XOR chain.
  function automatic int gray_inv(int g, int n);
    for (int b = 0; b < (1 << n); b++) begin
      if (gray_of(b) == g) return b;
    end
    return -1;
  endfunction

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, a, e);
    end
  endtask

  task automatic model_step();
    if (load) begin
      m4 = int'(lv4); m8 = int'(lv8); mw4 = 1'b0; mw8 = 1'b0;
    end else if (en) begin
      if (up_dn) begin
        mw4 = (m4 == 15); mw8 = (m8 == 255);
        m4 = (m4 + 1) % 16; m8 = (m8 + 1) % 256;
      end else begin
        mw4 = (m4 == 0); mw8 = (m8 == 0);
        m4 = (m4 + 15) % 16; m8 = (m8 + 255) % 256;
      end
    end else begin
      mw4 = 1'b0; mw8 = 1'b0;
    end
    md4 = gray_inv(int'(gin4), 4);
    md8 = gray_inv(int'(gin8), 8);
    mdv = gvld;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model();
    chk("bin4",  32'(bin4),  32'(m4));
    chk("gray4", 32'(gray4), 32'(gray_of(m4)));
    chk("wrap4", 32'(wrap4), 32'(mw4));
    chk("dec4",  32'(dec4),  32'(md4));
    chk("dvld4", 32'(dvld4), 32'(mdv));
    chk("bin8",  32'(bin8),  32'(m8));
    chk("gray8", 32'(gray8), 32'(gray_of(m8)));
    chk("wrap8", 32'(wrap8), 32'(mw8));
    chk("dec8",  32'(dec8),  32'(md8));
    chk("dvld8", 32'(dvld8), 32'(mdv));
  endtask

  initial begin
    logic [3:0] pg4;
    logic [7:0] pg8;

    rst_n = 1'b0; en = 1'b0; up_dn = 1'b0; load = 1'b0; gvld = 1'b0;
    lv4 = '0; lv8 = '0; gin4 = '0; gin8 = '0;
    m4 = 0; m8 = 254; mw4 = 1'b0; mw8 = 1'b0; md4 = 0; md8 = 0; mdv = 1'b0;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'b0111, 4'b0111, 4'b0100, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 4'b0000, 4'b1000, 4'b1100, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 4'b1111, 4'b1111, 4'b1000, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b1111, 4'b1000, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b1111, 4'b1000, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b1110, 4'b1001, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 4'b1010, 4'b1010, 4'b1111, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 4'b0000, 4'b1011, 4'b1110, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 4'b0011, 4'b0011, 4'b0010, 1'b0};
    for (int i = 11; i < 16; i++) tbl[i] = '{1'b0, 1'b0, 1'b1, 4'b1100, 4'b0011, 4'b0010, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_model();
    chk("rst_gray8_81", 32'(gray8), 32'h81);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 16; i++) begin
      load = tbl[i].load; en = tbl[i].en; up_dn = tbl[i].up_dn;
      lv4 = tbl[i].load_val; lv8 = {tbl[i].load_val, ~tbl[i].load_val};
      tick();
      chk($sformatf("tbl%0d_bin", i),  32'(bin4),  32'(tbl[i].exp_bin));
      chk($sformatf("tbl%0d_gray", i), 32'(gray4), 32'(tbl[i].exp_gray));
      chk($sformatf("tbl%0d_wrap", i), 32'(wrap4), 32'(tbl[i].exp_wrap));
      check_model();
    end

    // Asynchronous reset mid-count at 0101
    load = 1'b1; en = 1'b1; up_dn = 1'b1; lv4 = 4'b0101; lv8 = 8'h55;
    tick();
    chk("pre_rst_bin4", 32'(bin4), 32'h5);
    load = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_bin4",  32'(bin4),  32'h0);
    chk("arst_gray4", 32'(gray4), 32'h0);
    chk("arst_wrap4", 32'(wrap4), 32'h0);
    chk("arst_bin8",  32'(bin8),  32'hFE);
    chk("arst_gray8", 32'(gray8), 32'h81);
    m4 = 0; m8 = 254; mw4 = 1'b0; mw8 = 1'b0; md4 = 0; md8 = 0; mdv = 1'b0;
    #2 rst_n = 1'b1;

    // Full up lap: every step flips exactly one Gray bit
    en = 1'b1; up_dn = 1'b1; load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pg4 = gray4; pg8 = gray8;
      tick();
      check_model();
      chk("onebit4", 32'($countones(pg4 ^ gray4)), 32'd1);
      chk("onebit8", 32'($countones(pg8 ^ gray8)), 32'd1);
    end

    // Decode path
    en = 1'b0;
    gin4 = 4'b1101; gvld = 1'b1; gin8 = 8'h00;
    tick();
    chk("dec_1101", 32'(dec4), 32'b1001);
    chk("dec_vld1", 32'(dvld4), 32'd1);
    for (int x = 0; x < 256; x++) begin
      gin8 = 8'(gray_of(x)); gin4 = 4'(gray_of(x % 16)); gvld = x[0];
      tick();
      chk("sweep8", 32'(dec8), 32'(x));
      chk("sweep4", 32'(dec4), 32'(x % 16));
      chk("sweep_vld", 32'(dvld8), 32'(x[0]));
    end

    // Randomised run against the model
    for (int i = 0; i < 400; i++) begin
      load  = ($urandom_range(7) == 0);
      en    = ($urandom_range(3) != 0);
      up_dn = ($urandom_range(3) != 0);
      lv4   = 4'($urandom);
      lv8   = 8'($urandom);
      gin4  = 4'($urandom);
      gin8  = 8'($urandom);
      gvld  = 1'($urandom);
      tick();
      check_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_counter_nbits.md
Name: gray_counter_nbits

Overview:
Parametrised N-bit counter that keeps registered binary and Gray-code views of one count value.
- Supports enable, up/down and synchronous load.
- Includes a registered Gray-to-binary decode path for pointers arriving from another clock domain.
- Used as the read/write pointer engine in async FIFOs and anywhere a glitch-free, single-bit-change count must cross clock domains.

Parameters:
N, 8, counter/pointer width in bits; legal range 2..32.
RST_VAL, 0, binary count value loaded at reset; the Gray reset value is derived from it.

Ports:
clk  in  1  system clock; all flops rising-edge.
rst_n  in  1  asynchronous active-low reset.
en  in  1  count enable; one step per cycle while high.
up_dn  in  1  count direction: 1 = increment, 0 = decrement.
load  in  1  synchronous load strobe; takes priority over en.
load_val  in  N  binary value to load.
bin_out  out  N  registered binary count.
gray_out  out  N  registered Gray code of bin_out.
wrap  out  1  one-cycle pulse on wrap-around.
gray_in  in  N  external Gray pointer, already synchronised into clk.
gray_in_vld  in  1  qualifies gray_in.
dec_bin  out  N  registered binary decode of gray_in.
dec_vld  out  1  registered copy of gray_in_vld.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. It asserts immediately and deasserts synchronously to clk, handled upstream.
- Reset values:
  - bin_out = RST_VAL.
  - gray_out = RST_VAL ^ (RST_VAL >> 1).
  - wrap, dec_bin and dec_vld = 0.
- Reset mid-operation forces all of the above immediately, regardless of en or load.
- Next-state priority (evaluated each rising edge):
  1. load=1: bin_out <= load_val; wrap <= 0; en and up_dn ignored.
  2. en=1, up_dn=1: bin_out <= bin_out + 1, modulo 2^N.
  3. en=1, up_dn=0: bin_out <= bin_out - 1, modulo 2^N.
  4. en=0: hold; wrap <= 0.
- Gray output:
  - gray_out is a flop loaded with bin2gray(bin_next) on the same edge as bin_out.
  - It is never a combinational function of the bin_out flops. This keeps it glitch-free for CDC.
- Invariant: gray_out == bin_out ^ (bin_out >> 1) in every cycle after reset.
- Counting steps (en=1, load=0) change gray_out in exactly one bit. A load may change any number of bits.
- wrap:
  - Set for exactly one cycle, with the new count, when an up-step leaves all-ones or a down-step leaves zero.
  - Otherwise 0. Not asserted by a load, even if load_val wraps the value.
- Width rule: all arithmetic is N bits and the carry/borrow is discarded. wrap is the only overflow indication.
- Simultaneous load and en: load wins; no step is taken that cycle.
- Decode path:
  - dec_bin <= gray2bin(gray_in) every cycle, with dec_bin[N-1] = gray_in[N-1] and dec_bin[i] = dec_bin[i+1] ^ gray_in[i].
  - dec_vld <= gray_in_vld.
  - Latency is 1 cycle. The path is independent of the counter and has no back-pressure.
  - dec_bin updates even when gray_in_vld=0; consumers qualify it with dec_vld.
- Combinational depth: the gray2bin XOR chain is N-1 levels. This is acceptable for N<=32 at target frequency; no pipelining is required.

Decomposition:
- Shared package gray_pkg holds:
  - function bin2gray(N-bit), and function gray2bin(N-bit) as an XOR prefix chain written with a loop.
  - localparam N_MAX = 32.
- One natural sub-module, gray2bin_reg: N-bit registered decoder with the vld pipe. It is reused standalone on the FIFO's opposite-domain side.
- The counter core stays in the top module.

Test Plan:
- Reset: N=4, RST_VAL=0, pulse rst_n low mid-count at bin=0101 -> bin_out=0000, gray_out=0000, wrap=0, immediately and asynchronously.
- Up count: N=4, en=1, up_dn=1 from 0111 -> next bin 1000, gray 0100->1100. Continue from 1111 -> bin 0000, gray 1000->0000, wrap=1 for one cycle. A scoreboard checks a single-bit Gray change on all 16 steps.
- Down count: N=4, from 0000 with up_dn=0 -> bin 1111, gray 1000, wrap=1. Next step -> bin 1110, gray 1001, wrap=0.
- Load priority: N=4, load=1, en=1, load_val=1010 -> bin 1010, gray 1111, wrap=0. The next en cycle with up_dn=1 -> bin 1011, gray 1110.
- Hold: en=0, load=0 for 5 cycles at bin 0011 -> bin_out=0011 and gray_out=0010 stable; wrap=0.
- Decode: N=4, gray_in=1101, gray_in_vld=1 -> next cycle dec_bin=1001, dec_vld=1. Exhaustive sweep of all 16 gray_in values, checking gray2bin(bin2gray(x))==x. Repeat with N=8, RST_VAL=8'hFE for parameter coverage.
